// File: rtl/melody_player.sv
// Plays a fixed 16-entry song as a square wave: each entry sounds for NOTE_TICKS
// cycles, then stays silent for GAP_TICKS cycles. Optionally loops, can be aborted by stop.
module melody_player #(
    parameter logic [27:0] NOTE_TICKS = 28'd25000000,
    parameter logic [27:0] GAP_TICKS  = 28'd2500000,
    parameter int          DIV_SHIFT  = 0
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic       buzzer,
    output logic       busy,
    output logic [3:0] note_idx,
    output logic       done,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state;
    logic [27:0] dur_cnt;
    logic [17:0] tone_cnt;
    logic [3:0]  code;
    logic [17:0] base_div;
    logic [17:0] divisor;
    logic [17:0] half_div;
    logic        note_end;
    logic        gap_end;
    logic        tone_wrap;

    assign state_dbg = state;

    always_comb begin
        code = 4'd0;
        case (note_idx)
            4'd0:  code = 4'd1;
            4'd1:  code = 4'd2;
            4'd2:  code = 4'd3;
            4'd3:  code = 4'd4;
            4'd4:  code = 4'd5;
            4'd5:  code = 4'd6;
            4'd6:  code = 4'd7;
            4'd7:  code = 4'd8;
            4'd8:  code = 4'd0;
            4'd9:  code = 4'd8;
            4'd10: code = 4'd7;
            4'd11: code = 4'd6;
            4'd12: code = 4'd5;
            4'd13: code = 4'd4;
            4'd14: code = 4'd3;
            4'd15: code = 4'd2;
            default: code = 4'd0;
        endcase
    end

    // Divisor is the number of clocks per full period of the note.
    always_comb begin
        base_div = 18'd0;
        case (code)
            4'd1: base_div = 18'd191205;
            4'd2: base_div = 18'd170357;
            4'd3: base_div = 18'd151769;
            4'd4: base_div = 18'd143266;
            4'd5: base_div = 18'd127551;
            4'd6: base_div = 18'd113636;
            4'd7: base_div = 18'd101239;
            4'd8: base_div = 18'd95602;
            default: base_div = 18'd0;
        endcase
    end

    assign divisor   = base_div >> DIV_SHIFT;
    assign half_div  = divisor >> 1;
    assign note_end  = (dur_cnt == NOTE_TICKS - 28'd1);
    assign gap_end   = (dur_cnt == GAP_TICKS - 28'd1);
    assign tone_wrap = (tone_cnt == divisor - 18'd1);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            buzzer   <= 1'b0;
            busy     <= 1'b0;
            note_idx <= 4'd0;
            done     <= 1'b0;
            dur_cnt  <= 28'd0;
            tone_cnt <= 18'd0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                buzzer   <= 1'b0;
                busy     <= 1'b0;
                note_idx <= 4'd0;
                dur_cnt  <= 28'd0;
                tone_cnt <= 18'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= TONE;
                            busy     <= 1'b1;
                            note_idx <= 4'd0;
                            dur_cnt  <= 28'd0;
                            tone_cnt <= 18'd0;
                        end
                    end
                    TONE: begin
                        if (note_end) begin
                            state    <= GAP;
                            buzzer   <= 1'b0;
                            dur_cnt  <= 28'd0;
                            tone_cnt <= 18'd0;
                        end else begin
                            dur_cnt  <= dur_cnt + 28'd1;
                            tone_cnt <= tone_wrap ? 18'd0 : tone_cnt + 18'd1;
                            // Rest entries keep the speaker quiet for the whole entry.
                            buzzer   <= (code != 4'd0) && (tone_cnt < half_div);
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            dur_cnt <= 28'd0;
                            if (note_idx != 4'd15) begin
                                state    <= TONE;
                                note_idx <= note_idx + 4'd1;
                            end else if (loop) begin
                                state    <= TONE;
                                note_idx <= 4'd0;
                            end else begin
                                state    <= IDLE;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                                note_idx <= 4'd0;
                            end
                        end else begin
                            dur_cnt <= dur_cnt + 28'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_player.sv
// Randomized scoreboard bench for melody_player: a per-cycle expected trace is built
// from the song/divisor tables and compared against the DUT outputs on each falling edge.
module tb_melody_player;

    localparam int NOTE_N  = 1000;
    localparam int GAP_N   = 10;
    localparam int ENTRY_N = NOTE_N + GAP_N;
    localparam int DS      = 10;

    logic       clock_in = 1'b0;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       loop;
    logic       buzzer;
    logic       busy;
    logic [3:0] note_idx;
    logic       done;
    logic [1:0] state_dbg;

    int checks   = 0;
    int failures = 0;
    int mon_cyc  = 0;

    // Expected entry: {check_idx, busy, done, buzzer, note_idx[3:0]}
    logic [7:0] exp_q[$];
    logic [7:0] model_q[$];
    logic [7:0] mon_e;

    int song_tab [16] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 8, 7, 6, 5, 4, 3, 2};
    int div_tab  [9]  = '{0, 191205, 170357, 151769, 143266, 127551, 113636, 101239, 95602};

    melody_player #(
        .NOTE_TICKS(28'd1000),
        .GAP_TICKS (28'd10),
        .DIV_SHIFT (DS)
    ) dut (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .buzzer   (buzzer),
        .busy     (busy),
        .note_idx (note_idx),
        .done     (done),
        .state_dbg(state_dbg)
    );

    always #5 clock_in = ~clock_in;

    function automatic logic [7:0] pack(input bit chk, input bit b, input bit d, input bit bz, input int idx);
        logic [3:0] i4;
        i4 = idx[3:0];
        return {chk, b, d, bz, i4};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp_v);
        end
    endtask

    // Reference trace: each entry is NOTE_N tone cycles then GAP_N silent cycles.
    // The buzzer during tone cycle k (k>=1) is high while (k-1) mod divisor < divisor/2.
    task automatic build_model(input int passes);
        int code;
        int dv;
        int hf;
        bit bz;
        model_q.delete();
        for (int p = 0; p < passes; p++) begin
            for (int e = 0; e < 16; e++) begin
                code = song_tab[e];
                dv   = div_tab[code] >> DS;
                hf   = dv >> 1;
                for (int k = 0; k < NOTE_N; k++) begin
                    bz = 1'b0;
                    if (code != 0 && k >= 1) bz = (((k - 1) % dv) < hf);
                    model_q.push_back(pack(1'b1, 1'b1, 1'b0, bz, e));
                end
                for (int g = 0; g < GAP_N; g++) model_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, e));
            end
        end
    endtask

    task automatic push_model(input int last);
        for (int i = 0; i <= last; i++) exp_q.push_back(model_q[i]);
    endtask

    task automatic push_idle(input int n, input bit chk_idx);
        for (int i = 0; i < n; i++) exp_q.push_back(pack(chk_idx, 1'b0, 1'b0, 1'b0, 0));
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < limit) begin
            @(posedge clock_in);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // start is high for exactly one sampling edge; returns just after the TONE-entry edge.
    task automatic begin_play();
        @(posedge clock_in);
        #1 start = 1'b1;
        @(posedge clock_in);
        #1 start = 1'b0;
    endtask

    always @(negedge clock_in) begin
        mon_cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e[7]) begin
                if ({busy, done, buzzer, note_idx} !== mon_e[6:0]) begin
                    failures++;
                    $display("FAIL trace cycle=%0d actual{busy,done,buzzer,idx}=%b required=%b",
                             mon_cyc, {busy, done, buzzer, note_idx}, mon_e[6:0]);
                end
            end else begin
                if ({busy, done, buzzer} !== mon_e[6:4]) begin
                    failures++;
                    $display("FAIL trace cycle=%0d actual{busy,done,buzzer}=%b required=%b",
                             mon_cyc, {busy, done, buzzer}, mon_e[6:4]);
                end
            end
        end
    end

    initial begin
        int n;
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop    = 1'b0;

        // Reset state
        #1 check("reset_init", {1'b0, busy, done, buzzer, note_idx}, 8'h00);
        check("reset_state", {6'd0, state_dbg}, 8'h00);
        repeat (3) @(posedge clock_in);
        #2 reset_n = 1'b1;
        push_idle(10, 1'b1);
        drain(50);

        // Single play without loop: 16 entries, one done pulse, silent afterwards
        repeat ($urandom_range(1, 20)) @(posedge clock_in);
        loop = 1'b0;
        begin_play();
        build_model(1);
        push_model(16 * ENTRY_N - 1);
        exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 1'b0, 0));
        push_idle(20, 1'b0);
        drain(16 * ENTRY_N + 100);

        // Looping: wraps to entry 0 without done, then stopped partway into pass two
        repeat ($urandom_range(1, 20)) @(posedge clock_in);
        loop = 1'b1;
        begin_play();
        build_model(2);
        n = 16 * ENTRY_N + $urandom_range(20, 1500);
        push_model(n);
        push_idle(20, 1'b1);
        repeat (n) @(posedge clock_in);
        #1 stop = 1'b1;
        @(posedge clock_in);
        #1 stop = 1'b0;
        loop = 1'b0;
        drain(200);

        // Stop together with start while entry 5 is playing
        repeat ($urandom_range(1, 20)) @(posedge clock_in);
        begin_play();
        build_model(1);
        n = 5 * ENTRY_N + $urandom_range(0, ENTRY_N - 1);
        push_model(n);
        push_idle(20, 1'b1);
        repeat (n) @(posedge clock_in);
        #1 stop = 1'b1;
        start = 1'b1;
        @(posedge clock_in);
        #1 stop = 1'b0;
        start = 1'b0;
        drain(200);

        // Asynchronous reset between edges while entry 1 drives the buzzer high
        repeat ($urandom_range(1, 20)) @(posedge clock_in);
        begin_play();
        build_model(1);
        n = ENTRY_N + $urandom_range(1, 80);
        push_model(n);
        repeat (n) @(posedge clock_in);
        @(negedge clock_in);
        #2 reset_n = 1'b0;
        start = 1'b1;
        #1 check("reset_async", {1'b0, busy, done, buzzer, note_idx}, 8'h00);
        check("reset_async_state", {6'd0, state_dbg}, 8'h00);
        push_idle(6, 1'b1);
        repeat (4) @(posedge clock_in);
        #3 start = 1'b0;
        reset_n = 1'b1;
        push_idle(10, 1'b1);
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 Parameter NOTE_TICKS, default 28'd25000000, is the number of clock cycles each table entry sounds.
REQ-002 Parameter GAP_TICKS, default 28'd2500000, is the number of silent clock cycles after each entry.
REQ-003 Parameter DIV_SHIFT, default 0, right-shifts every divisor in the table (simulation speed-up only).
REQ-004 Port clock_in, input, 1 bit, is the single system clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1 bit, is an asynchronous active-low reset.
REQ-006 Port start, input, 1 bit, is a level-sampled request to begin playback.
REQ-007 Port stop, input, 1 bit, aborts playback.
REQ-008 Port loop, input, 1 bit, restarts the song after the last entry when high.
REQ-009 Port buzzer, output, 1 bit, is the registered square-wave drive to the speaker.
REQ-010 Port busy, output, 1 bit, is high in TONE or GAP.
REQ-011 Port note_idx, output, 4 bits, is the current song-table index.
REQ-012 Port done, output, 1 bit, is a one-cycle pulse when a non-looping song completes.

Function
REQ-013 The block SHALL hold an 18-bit divisor table indexed by note code: 0 rest, 1 do 191205, 2 re 170357, 3 mi 151769, 4 fa 143266, 5 sol 127551, 6 la 113636, 7 si 101239, 8 do_alto 95602.
REQ-014 The effective divisor SHALL be table value >> DIV_SHIFT, and its half SHALL be that value >> 1, truncated.
REQ-015 The 16-entry song ROM SHALL hold codes, index 0..15: 1,2,3,4,5,6,7,8,0,8,7,6,5,4,3,2.
REQ-016 The FSM SHALL have exactly three states: IDLE, TONE, GAP.
REQ-017 In IDLE with start=1 and stop=0, the next state SHALL be TONE with note_idx=0.
REQ-018 In TONE or GAP, start SHALL be ignored.
REQ-019 TONE SHALL last exactly NOTE_TICKS cycles and then go to GAP.
REQ-020 GAP SHALL last exactly GAP_TICKS cycles; a 28-bit duration counter SHALL be cleared on every state entry.
REQ-021 At the end of GAP with note_idx<15, the FSM SHALL enter TONE with note_idx+1.
REQ-022 At the end of GAP with note_idx=15 and loop=1, the FSM SHALL enter TONE with note_idx=0 and SHALL NOT pulse done.
REQ-023 At the end of GAP with note_idx=15 and loop=0, the FSM SHALL enter IDLE and pulse done for exactly one cycle.
REQ-024 When stop=1 in any state, the FSM SHALL enter IDLE on the next edge with note_idx=0 and buzzer=0, and SHALL NOT pulse done; stop SHALL win over start.
REQ-025 An 18-bit tone counter SHALL clear on TONE entry, increment each TONE cycle, and wrap to 0 after reaching divisor-1.
REQ-026 In TONE with a non-zero code, buzzer SHALL be registered as (tone counter < half divisor), giving one cycle of latency.
REQ-027 In TONE with code 0, and in IDLE and GAP, buzzer SHALL be 0.
REQ-028 loop SHALL be sampled only at the end of GAP for entry 15.

Reset
REQ-029 While reset_n=0, the block SHALL immediately force state=IDLE, buzzer=0, busy=0, note_idx=0, done=0, and both counters to 0, including mid-song.
REQ-030 After reset_n rises, the block SHALL remain in IDLE until start is sampled high.

Verification (parameters: NOTE_TICKS=1000, GAP_TICKS=10, DIV_SHIFT=10)
REQ-031 Single play:
- stimulus: pulse start with loop=0;
- required response: busy high for 16*1010 cycles; note_idx steps 0..15; one done pulse; buzzer 0 afterwards.
REQ-032 Tone shape:
- stimulus: entry 0 (divisor 186);
- required response: buzzer high 93 cycles, low 93 cycles, repeating; first rise one cycle after TONE entry.
REQ-033 Rest and gap:
- stimulus: entry 8, and every GAP;
- required response: buzzer stays 0 for the full 1000-cycle entry 8 and every 10-cycle GAP.
REQ-034 Loop:
- stimulus: loop=1;
- required response: after entry 15's GAP, note_idx returns to 0 with TONE; no done pulse; busy stays high.
REQ-035 Stop with start:
- stimulus: assert stop together with start at note_idx=5;
- required response: next cycle IDLE, note_idx=0, buzzer=0, no done.
REQ-036 Async reset:
- stimulus: drop reset_n mid-TONE, between clock edges;
- required response: all outputs 0 before the next edge; start ignored until reset_n=1.
